// File: rtl/div_pkg.sv
// Shared types and constants for the radix-2 SRT divider sequencer.
package div_pkg;

  localparam int unsigned DIV_W = 16;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  // Quotient digit codes presented to the on-the-fly converter.
  typedef enum logic [1:0] {
    DIG_ZERO = 2'b00,
    DIG_NEG  = 2'b01,
    DIG_POS  = 2'b10
  } digit_t;

  // Partial-remainder update select.
  typedef enum logic [1:0] {
    SEL_PASS = 2'b00,
    SEL_SUB  = 2'b01,
    SEL_ADD  = 2'b10
  } rsel_t;

endpackage

// File: rtl/srt_div_ctrl_if.sv
// Request/result and converter-side signals of the SRT divider sequencer.
interface srt_div_ctrl_if
  import div_pkg::*;
#(
  parameter int unsigned W = DIV_W
);

  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic         err;
  logic         conv_clr;
  logic         conv_valid;
  logic [1:0]   conv_in;
  logic         use_qm;
  logic [W-1:0] rem;

  modport master (
    output start, dividend, divisor,
    input  busy, done, err, conv_clr, conv_valid, conv_in, use_qm, rem
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, err, conv_clr, conv_valid, conv_in, use_qm, rem
  );

endinterface

// File: rtl/srt_digit_sel.sv
// Quotient digit selection from the 4-bit truncated estimate of 2*R.
module srt_digit_sel
  import div_pkg::*;
(
  input  logic [3:0] i_p_top,
  output digit_t     o_digit_c,
  output rsel_t      o_sel_c
);

  // Signed estimate >= +1/2 picks +1, <= -3/4 picks -1, otherwise 0.
  always_comb begin
    o_digit_c = DIG_ZERO;
    o_sel_c   = SEL_PASS;
    if ($signed(i_p_top) >= $signed(4'b0010)) begin
      o_digit_c = DIG_POS;
      o_sel_c   = SEL_SUB;
    end else if ($signed(i_p_top) <= $signed(4'b1101)) begin
      o_digit_c = DIG_NEG;
      o_sel_c   = SEL_ADD;
    end
  end

endmodule

// File: rtl/srt_div_ctrl.sv
// Radix-2 SRT fractional divide sequencer: one signed digit per ITER cycle,
// final remainder correction in FIX, result reported with a done pulse.
module srt_div_ctrl
  import div_pkg::*;
#(
  parameter int unsigned W = DIV_W
)(
  input logic           clk,
  input logic           reset,
  srt_div_ctrl_if.slave bus
);

  // Remainder/divisor: sign bit, one integer bit, W fraction bits.
  localparam int unsigned RW = W + 2;
  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

  state_t          r_state;
  state_t          w_next;

  logic [RW-1:0]   r_part;
  logic [RW-1:0]   r_div;
  logic [CW-1:0]   r_count;

  logic            r_busy;
  logic            r_done;
  logic            r_err;
  logic            r_conv_clr;
  logic            r_conv_valid;
  digit_t          r_conv_in;
  logic            r_use_qm;
  logic [W-1:0]    r_rem;

  logic [RW-1:0]   w_r_cur;
  logic [RW-1:0]   w_d_cur;
  logic [RW-1:0]   w_p;
  logic [RW-1:0]   w_r_step;
  logic [W-1:0]    w_rem_fix;
  logic            w_op_err;
  digit_t          w_digit;
  rsel_t           w_sel;

  logic            w_busy_d;
  logic            w_done_d;
  logic            w_err_d;
  logic            w_conv_clr_d;
  logic            w_conv_valid_d;
  digit_t          w_conv_in_d;
  logic            w_use_qm_d;
  logic [W-1:0]    w_rem_d;

  // In LOAD the first digit is formed straight from the operands so that
  // its registered code lines up with the first ITER cycle.
  assign w_r_cur   = (r_state == LOAD) ? {2'b00, bus.dividend} : r_part;
  assign w_d_cur   = (r_state == LOAD) ? {2'b00, bus.divisor}  : r_div;
  assign w_p       = w_r_cur << 1;
  assign w_op_err  = !bus.divisor[W-1] || (bus.dividend >= bus.divisor);
  assign w_rem_fix = r_part[RW-1] ? W'(r_part + r_div) : r_part[W-1:0];

  srt_digit_sel u_digit_sel (
    .i_p_top   (w_p[RW-1:RW-4]),
    .o_digit_c (w_digit),
    .o_sel_c   (w_sel)
  );

  // Remainder recurrence: 3-way select of P-D / P+D / P.
  always_comb begin
    w_r_step = w_p;
    case (w_sel)
      SEL_SUB: w_r_step = w_p - w_d_cur;
      SEL_ADD: w_r_step = w_p + w_d_cur;
      default: w_r_step = w_p;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_next = LOAD;
      LOAD:    w_next = w_op_err ? DONE : ITER;
      ITER:    if (r_count == CW'(W - 1)) w_next = FIX;
      FIX:     w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Output decode from the state being entered, so registered outputs track state.
  always_comb begin
    w_busy_d       = 1'b0;
    w_done_d       = 1'b0;
    w_err_d        = 1'b0;
    w_conv_clr_d   = 1'b0;
    w_conv_valid_d = 1'b0;
    w_conv_in_d    = DIG_ZERO;
    w_use_qm_d     = 1'b0;
    w_rem_d        = r_rem;
    case (w_next)
      LOAD: begin
        w_busy_d     = 1'b1;
        w_conv_clr_d = 1'b1;
      end
      ITER: begin
        w_busy_d       = 1'b1;
        w_conv_valid_d = 1'b1;
        w_conv_in_d    = w_digit;
      end
      FIX: begin
        w_busy_d = 1'b1;
      end
      DONE: begin
        w_done_d = 1'b1;
        if (r_state == LOAD) begin
          w_err_d = 1'b1;
          w_rem_d = bus.dividend;
        end else begin
          w_use_qm_d = r_part[RW-1];
          w_rem_d    = w_rem_fix;
        end
      end
      default: ;
    endcase
  end

  // Output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_conv_clr   <= 1'b0;
      r_conv_valid <= 1'b0;
      r_conv_in    <= DIG_ZERO;
      r_use_qm     <= 1'b0;
      r_rem        <= '0;
    end else begin
      r_busy       <= w_busy_d;
      r_done       <= w_done_d;
      r_err        <= w_err_d;
      r_conv_clr   <= w_conv_clr_d;
      r_conv_valid <= w_conv_valid_d;
      r_conv_in    <= w_conv_in_d;
      r_use_qm     <= w_use_qm_d;
      r_rem        <= w_rem_d;
    end
  end

  // Datapath: operand capture, partial remainder and iteration count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_part  <= '0;
      r_div   <= '0;
      r_count <= '0;
    end else begin
      case (r_state)
        LOAD: begin
          r_div   <= w_d_cur;
          r_count <= '0;
          r_part  <= (w_next == ITER) ? w_r_step : w_r_cur;
        end
        ITER: begin
          if (w_next == ITER) begin
            r_part  <= w_r_step;
            r_count <= r_count + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.err        = r_err;
  assign bus.conv_clr   = r_conv_clr;
  assign bus.conv_valid = r_conv_valid;
  assign bus.conv_in    = r_conv_in;
  assign bus.use_qm     = r_use_qm;
  assign bus.rem        = r_rem;

endmodule

// File: tb/tb_srt_div_ctrl.sv
// Bench for srt_div_ctrl: table vectors, abort/held-start sequences and random ops,
// checked through a converter model and an expected-result queue.
module tb_srt_div_ctrl;
  import div_pkg::*;

  localparam int unsigned W      = DIV_W;
  localparam int unsigned N_RAND = 2000;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] rem;
    logic         err;
    int           lat;
  } exp_t;

  typedef struct {
    logic [W-1:0] x;
    logic [W-1:0] d;
    logic         err;
    logic [W-1:0] q;
    logic [W-1:0] rem;
  } vec_t;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_err;
  int   load_cyc;
  int   last_gap;
  exp_t sb[$];

  srt_div_ctrl_if #(.W(W)) bus ();

  srt_div_ctrl #(.W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: floor(x*2^W/d) and the matching remainder.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] d);
    exp_t e;
    logic [2*W-1:0] num;
    logic [2*W-1:0] den;
    e.err = (d[W-1] == 1'b0) || (x >= d);
    e.lat = e.err ? 1 : W + 2;
    e.q   = '0;
    e.rem = '0;
    if (!e.err) begin
      num   = {x, {W{1'b0}}};
      den   = {{W{1'b0}}, d};
      e.q   = W'(num / den);
      e.rem = W'(num % den);
    end
    return e;
  endfunction

  // Converter model and result checker, sampling on the falling edge.
  task automatic monitor_loop();
    longint conv_q   = 0;
    longint qv       = 0;
    int     n_valid  = 0;
    int     cyc      = 0;
    bit     in_op    = 0;
    bit     bad_code = 0;
    bit     overlap  = 0;
    exp_t   e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset) begin
        chk("reset_outputs", 64'({bus.busy, bus.done, bus.err, bus.conv_clr,
                                  bus.conv_valid, bus.use_qm, bus.conv_in, bus.rem}), 64'(0));
        sb.delete();
        in_op = 0;
      end else begin
        if (bus.conv_clr) begin
          chk("load_expected", 64'(!in_op && sb.size() > 0), 64'(1));
          chk("busy_in_load", 64'(bus.busy), 64'(1));
          last_gap = cyc - load_cyc;
          load_cyc = cyc;
          in_op    = 1;
          conv_q   = 0;
          n_valid  = 0;
          bad_code = 0;
          overlap  = bus.conv_valid;
        end else if (bus.conv_valid) begin
          n_valid++;
          case (bus.conv_in)
            2'b10:   conv_q = 2 * conv_q + 1;
            2'b01:   conv_q = 2 * conv_q - 1;
            2'b00:   conv_q = 2 * conv_q;
            default: bad_code = 1;
          endcase
        end
        if (bus.done) begin
          chk("pending_at_done", 64'(sb.size() > 0), 64'(1));
          if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("done_latency", 64'(cyc - load_cyc), 64'(e.lat));
            chk("err", 64'(bus.err), 64'(e.err));
            chk("busy_in_done", 64'(bus.busy), 64'(0));
            chk("conv_valid_count", 64'(n_valid), e.err ? 64'(0) : 64'(W));
            chk("code11_or_clr_overlap", 64'({bad_code, overlap}), 64'(0));
            if (!e.err) begin
              qv = bus.use_qm ? conv_q - 1 : conv_q;
              chk("quotient", qv, 64'(e.q));
              chk("rem", 64'(bus.rem), 64'(e.rem));
            end
          end
          in_op = 0;
        end
      end
    end
  endtask

  task automatic wait_drain(input string name);
    int i = 0;
    while (sb.size() != 0 && i < 80) begin
      @(posedge clk);
      i++;
    end
    #1;
    chk(name, 64'(sb.size()), 64'(0));
    sb.delete();
  endtask

  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] d, input exp_t e);
    @(posedge clk); #1;
    bus.start    = 1'b1;
    bus.dividend = x;
    bus.divisor  = d;
    sb.push_back(e);
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    bus.dividend = W'($urandom);
    bus.divisor  = W'($urandom);
    wait_drain("op_drain");
  endtask

  initial begin
    vec_t tbl[10];
    exp_t e;
    logic [W-1:0] x;
    logic [W-1:0] d;

    tbl[0] = '{16'h4000, 16'h8000, 1'b0, 16'h8000, 16'h0000};
    tbl[1] = '{16'h5555, 16'hFFFF, 1'b0, 16'h5555, 16'h5555};
    tbl[2] = '{16'h1234, 16'h4000, 1'b1, 16'h0000, 16'h0000};
    tbl[3] = '{16'h9000, 16'h8000, 1'b1, 16'h0000, 16'h0000};
    tbl[4] = '{16'h0000, 16'h8000, 1'b0, 16'h0000, 16'h0000};
    tbl[5] = '{16'h8000, 16'h8000, 1'b1, 16'h0000, 16'h0000};
    tbl[6] = '{16'h7FFF, 16'h8000, 1'b0, 16'hFFFE, 16'h0000};
    tbl[7] = '{16'hFFFE, 16'hFFFF, 1'b0, 16'hFFFE, 16'hFFFE};
    tbl[8] = '{16'h0001, 16'h8000, 1'b0, 16'h0002, 16'h0000};
    tbl[9] = '{16'h0000, 16'h0000, 1'b1, 16'h0000, 16'h0000};

    n_checks     = 0;
    n_err        = 0;
    load_cyc     = 0;
    last_gap     = 0;
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    fork
      monitor_loop();
    join_none
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;

    // Table vectors.
    foreach (tbl[i]) begin
      e.err = tbl[i].err;
      e.q   = tbl[i].q;
      e.rem = tbl[i].rem;
      e.lat = tbl[i].err ? 1 : W + 2;
      do_op(tbl[i].x, tbl[i].d, e);
    end

    // Abort with reset during the 7th digit, then a clean op.
    @(posedge clk); #1;
    bus.start    = 1'b1;
    bus.dividend = 16'h5555;
    bus.divisor  = 16'hFFFF;
    sb.push_back(model(16'h5555, 16'hFFFF));
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (6) @(posedge clk);
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    chk("abort_idle_busy", 64'(bus.busy), 64'(0));
    chk("abort_no_pending", 64'(sb.size()), 64'(0));
    do_op(16'h5555, 16'hFFFF, model(16'h5555, 16'hFFFF));

    // Start held high across two operations: one LOAD per IDLE visit.
    @(posedge clk); #1;
    bus.start    = 1'b1;
    bus.dividend = 16'h4000;
    bus.divisor  = 16'h8000;
    sb.push_back(model(16'h4000, 16'h8000));
    sb.push_back(model(16'h4000, 16'h8000));
    repeat (25) @(posedge clk);
    #1 bus.start = 1'b0;
    wait_drain("held_drain");
    chk("held_load_gap", 64'(last_gap), 64'(W + 4));
    repeat (25) @(posedge clk);
    do_op(16'h3000, 16'hC000, model(16'h3000, 16'hC000));

    // Random operands, mostly normalised with x<d, some error cases.
    for (int n = 0; n < N_RAND; n++) begin
      d = {1'b1, (W-1)'($urandom)};
      x = W'($urandom_range(0, 32'(d) - 1));
      if (n % 97 == 3)  x = d - W'(1);
      if (n % 64 == 5)  d[W-1] = 1'b0;
      if (n % 64 == 9)  x = d;
      do_op(x, d, model(x, d));
    end

    repeat (5) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
